regincr_accum: RTL and testbench
================================

Name: regincr_accum

Overview:
- Downstream consumer of the registered incrementer's output stream.
- Accepts a stream of p_nbits values over a val/rdy handshake and sums each batch of p_count accepted values.
- Presents each batch sum on a val/rdy output port and holds it until the sink takes it.
- Sits between the incrementer stage and the test sink or next datapath stage; it adds back-pressure the incrementer itself lacks.

Parameters:
- p_nbits, 8, width of each input value.
- p_count, 4, values per batch; legal range 1..255.
- p_sum_nbits, 16, width of the accumulated sum; must be >= p_nbits.

Ports:
- clk  input  1  clock; all state updates on the posedge.
- reset  input  1  synchronous, active-high reset.
- in_msg  input  p_nbits  input value.
- in_val  input  1  input valid.
- in_rdy  output  1  input ready.
- out_msg  output  p_sum_nbits  batch sum.
- out_val  output  1  output valid.
- out_rdy  input  1  output ready.

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-high.
- Internal state:
  - state in {ACCUM, DONE}.
  - sum_reg, p_sum_nbits bits.
  - cnt_reg, 8 bits.
- Reset: state=ACCUM, sum_reg=0, cnt_reg=0. Outputs after reset: in_rdy=1, out_val=0, out_msg=0.
- Reset has priority over every handshake. Asserting reset mid-batch or in DONE discards the partial or pending sum.
- Transfers:
  - Input transfer = in_val && in_rdy.
  - Output transfer = out_val && out_rdy.
- ACCUM state:
  - in_rdy=1, out_val=0.
  - On an input transfer: sum_reg += zero-extended in_msg, and cnt_reg += 1.
  - If that transfer is the p_count-th of the batch (cnt_reg == p_count-1 before the update), next state is DONE.
- DONE state:
  - out_val=1, out_msg=sum_reg, in_rdy=0.
  - On an output transfer: sum_reg=0, cnt_reg=0, next state is ACCUM.
- out_msg is combinationally equal to sum_reg in all states; it is undefined to the sink unless out_val=1.
- Latency: the sum is valid on out_val in the cycle after the last input transfer of the batch.
- Arithmetic: addition wraps modulo 2^p_sum_nbits. No saturation and no overflow flag.
- Inputs in_val and in_msg are ignored while in_rdy=0.
- out_msg is stable while out_val=1 and out_rdy=0.
- p_count=1: every accepted input goes straight to DONE with sum = that input.
- Throughput without the optional feature: at most p_count inputs per p_count+1 cycles, since DONE always costs at least one cycle.

Optional Feature:
- Macro: REGINCR_ACCUM_OVERLAP_EN.
- Defined:
  - In DONE, in_rdy = out_rdy.
  - A simultaneous output and input transfer starts the next batch with sum_reg = in_msg and cnt_reg = 1.
  - Next state is ACCUM, or stays DONE if p_count=1.
  - Result: full throughput of one input per cycle.
- Undefined: in_rdy=0 in DONE, exactly as specified in Behaviour.

Test Plan:
- Reset, then p_count=4, in_val=1 with in_msg 1,2,3,4 on back-to-back cycles, out_rdy=1 -> out_val=1 on the cycle after the 4th accept with out_msg=0x000A; in_rdy=0 during that cycle (overlap off).
- Sink stall: same batch with out_rdy=0 for 5 cycles -> out_val held at 1, out_msg held at 0x000A, in_rdy=0 throughout; the transfer fires when out_rdy=1; the next batch starts from sum 0.
- Source bubbles: in_val pattern 1,0,0,1,1,0,1 with values 5,x,x,6,7,x,8 -> out_msg=0x001A, with only valid cycles counted.
- Wrap: p_sum_nbits=8, p_nbits=8, inputs 0xFF,0xFF,0x02,0x01 -> out_msg=0x01.
- Reset mid-batch: accept 9,9 then assert reset for 1 cycle, then feed 1,1,1,1 -> out_msg=0x0004, and out_val stays 0 until that batch completes.
- With REGINCR_ACCUM_OVERLAP_EN and in_val=1, out_rdy=1 held high, input stream 1..8 -> out_msg 0x000A then 0x001A, with in_rdy=1 every cycle after reset.

Source files
------------

// File: rtl/regincr_accum.sv
// Batch accumulator: sums every p_count accepted inputs and holds the sum on a val/rdy output.
// Optional macro REGINCR_ACCUM_OVERLAP_EN lets the next batch start in the same cycle the sum is taken.
module regincr_accum #(
  parameter int p_nbits     = 8,
  parameter int p_count     = 4,
  parameter int p_sum_nbits = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_nbits-1:0]     in_msg,
  input  logic                   in_val,
  output logic                   in_rdy,
  output logic [p_sum_nbits-1:0] out_msg,
  output logic                   out_val,
  input  logic                   out_rdy
);

  typedef enum logic {ACCUM, DONE} state_t;

  localparam logic [7:0] LAST = 8'(p_count - 1);

  state_t                 state;
  logic [p_sum_nbits-1:0] sum_reg;
  logic [7:0]             cnt_reg;
  logic [p_sum_nbits-1:0] in_ext;
  logic                   in_xfer;
  logic                   out_xfer;

  assign in_ext   = p_sum_nbits'(in_msg);
  assign out_val  = (state == DONE);
  assign out_msg  = sum_reg;

`ifdef REGINCR_ACCUM_OVERLAP_EN
  assign in_rdy   = (state == ACCUM) || out_rdy;
`else
  assign in_rdy   = (state == ACCUM);
`endif

  assign in_xfer  = in_val && in_rdy;
  assign out_xfer = out_val && out_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACCUM;
      sum_reg <= '0;
      cnt_reg <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_xfer) begin
            sum_reg <= sum_reg + in_ext;
            cnt_reg <= cnt_reg + 8'd1;
            if (cnt_reg == LAST) state <= DONE;
          end
        end
        DONE: begin
          if (out_xfer) begin
`ifdef REGINCR_ACCUM_OVERLAP_EN
            // A same-cycle input seeds the next batch instead of being dropped.
            if (in_xfer) begin
              sum_reg <= in_ext;
              cnt_reg <= 8'd1;
              state   <= (p_count == 1) ? DONE : ACCUM;
            end else begin
              sum_reg <= '0;
              cnt_reg <= '0;
              state   <= ACCUM;
            end
`else
            sum_reg <= '0;
            cnt_reg <= '0;
            state   <= ACCUM;
`endif
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_regincr_accum.sv
// Self-checking bench for regincr_accum: a 16-bit-sum and an 8-bit-sum instance run in lockstep.
module tb_regincr_accum;

  localparam int CNT = 4;
`ifdef REGINCR_ACCUM_OVERLAP_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_msg;
  logic        in_val, out_rdy;
  logic        in_rdy, out_val, in_rdy8, out_val8;
  logic [15:0] out_msg;
  logic [7:0]  out_msg8;

  always #5 clk = ~clk;

  regincr_accum #(.p_nbits(8), .p_count(CNT), .p_sum_nbits(16)) dut (
    .clk(clk), .reset(reset), .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy),
    .out_msg(out_msg), .out_val(out_val), .out_rdy(out_rdy));

  regincr_accum #(.p_nbits(8), .p_count(CNT), .p_sum_nbits(8)) dut8 (
    .clk(clk), .reset(reset), .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy8),
    .out_msg(out_msg8), .out_val(out_val8), .out_rdy(out_rdy));

  int checks = 0;
  int errors = 0;

  // Reference: list of accepted values of the open batch, plus a pending completed sum.
  int unsigned acc_q[$];
  bit          pending;
  int unsigned done_sum;

  logic        s_rdy, s_val;
  logic [15:0] s_msg;
  logic [7:0]  s_msg8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    acc_q.delete();
    pending  = 1'b0;
    done_sum = 0;
  endtask

  task automatic step(input logic v, input logic [7:0] m, input logic r);
    bit ix, ox, er;
    int unsigned s, ds;
    logic [15:0] e16;
    logic [7:0]  e8;
    @(negedge clk);
    in_val = v; in_msg = m; out_rdy = r;
    #1;
    s_rdy = in_rdy; s_val = out_val; s_msg = out_msg; s_msg8 = out_msg8;
    er = !pending || (OV && r);
    chk("in_rdy", in_rdy, er);
    chk("out_val", out_val, pending);
    chk("in_rdy8", in_rdy8, er);
    chk("out_val8", out_val8, pending);
    if (pending) begin
      ds  = done_sum;
      e16 = ds[15:0];
      e8  = ds[7:0];
      chk("out_msg", out_msg, e16);
      chk("out_msg8", out_msg8, e8);
    end
    ix = v && er;
    ox = pending && r;
    @(posedge clk);
    if (ox) pending = 1'b0;
    if (ix) begin
      acc_q.push_back(m);
      if (acc_q.size() == CNT) begin
        s = 0;
        foreach (acc_q[k]) s += acc_q[k];
        done_sum = s;
        pending  = 1'b1;
        acc_q.delete();
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_val = 1'b0; out_rdy = 1'b0; in_msg = 8'h00;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_in_rdy", in_rdy, 1'b1);
    chk("rst_out_val", out_val, 1'b0);
    chk("rst_out_msg", out_msg, 16'h0000);
    chk("rst_out_msg8", out_msg8, 8'h00);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  m;
    logic        r;
    logic        e_rdy;
    logic        e_val;
    logic [15:0] e_msg;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[2] = '{1'b1, 8'd3, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[3] = '{1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 16'h0000};
    tbl[4] = '{1'b0, 8'd0, 1'b1, OV,   1'b1, 16'h000A};
    tbl[5] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 16'h0000};

    reset = 1'b1; in_val = 1'b0; in_msg = 8'h00; out_rdy = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Basic batch 1..4 from the table.
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].m, tbl[i].r);
      chk($sformatf("tbl%0d_rdy", i), s_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_val", i), s_val, tbl[i].e_val);
      if (tbl[i].e_val) chk($sformatf("tbl%0d_msg", i), s_msg, tbl[i].e_msg);
    end

    // Sink stall: sum held, junk inputs ignored, then next batch starts from zero.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h55, 1'b0);
      chk("stall_val", s_val, 1'b1);
      chk("stall_msg", s_msg, 16'h000A);
      chk("stall_rdy", s_rdy, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("stall_release_msg", s_msg, 16'h000A);
    for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("after_stall_msg", s_msg, 16'h0004);

    // Source bubbles.
    step(1'b1, 8'd5, 1'b1); step(1'b0, 8'hEE, 1'b1); step(1'b0, 8'hEE, 1'b1);
    step(1'b1, 8'd6, 1'b1); step(1'b1, 8'd7, 1'b1); step(1'b0, 8'hEE, 1'b1);
    step(1'b1, 8'd8, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("bubble_val", s_val, 1'b1);
    chk("bubble_msg", s_msg, 16'h001A);

    // Wraparound on the narrow instance.
    step(1'b1, 8'hFF, 1'b1); step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'h02, 1'b1); step(1'b1, 8'h01, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("wrap_msg8", s_msg8, 8'h01);
    chk("wrap_msg16", s_msg, 16'h0201);

    // Reset mid-batch discards the partial sum.
    step(1'b1, 8'd9, 1'b1); step(1'b1, 8'd9, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'd1, 1'b1);
      chk("midrst_val_low", s_val, 1'b0);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("midrst_msg", s_msg, 16'h0004);

    // Reset while a sum is pending.
    for (int i = 0; i < 4; i++) step(1'b1, 8'd3, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    do_reset();

`ifdef REGINCR_ACCUM_OVERLAP_EN
    begin
      int k = 0;
      logic [15:0] exp_s [2];
      exp_s[0] = 16'h000A; exp_s[1] = 16'h001A;
      for (int i = 1; i <= 9; i++) begin
        step(i <= 8, 8'(i), 1'b1);
        chk("ov_rdy", s_rdy, 1'b1);
        if (s_val && k < 2) begin
          chk("ov_msg", s_msg, exp_s[k]);
          k++;
        end
      end
      chk("ov_batches", k, 2);
    end
`endif

    // Randomized traffic against the reference.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
